// File: rtl/vga_timing_core_if.sv
// vga_timing_core_if: video timing bus between the raster generator and the video generator
// Optional macro VGA_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
// Ports (master = timing core):
//   pix_en, run                       : core inputs (pixel enable, run/halt request)
//   x, y                              : raw pixel column / line counters
//   active, sof, sol                  : undelayed visible flag and start strobes
//   hsync, vsync, blank_b, sync_b     : sync/blank strobes delayed by PIPE pixels
//   frame_cnt                         : frame counter (VGA_FRAME_CNT_EN only)
interface vga_timing_core_if #(parameter int CW = 10);
  logic pix_en;
  logic run;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic active;
  logic hsync;
  logic vsync;
  logic blank_b;
  logic sync_b;
  logic sof;
  logic sol;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  modport master (input pix_en, run,
                  output x, y, active, hsync, vsync, blank_b, sync_b, sof, sol, frame_cnt);
  modport slave  (output pix_en, run,
                  input x, y, active, hsync, vsync, blank_b, sync_b, sof, sol, frame_cnt);
`else
  modport master (input pix_en, run,
                  output x, y, active, hsync, vsync, blank_b, sync_b, sof, sol);
  modport slave  (output pix_en, run,
                  input x, y, active, hsync, vsync, blank_b, sync_b, sof, sol);
`endif
endinterface

// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA raster timing generator with pixel enable, run/halt and delayed sync/blank
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame counter on bus.frame_cnt.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : vga_timing_core_if.master (pix_en/run in; x, y, active, hsync, vsync,
//           blank_b, sync_b, sof, sol, [frame_cnt] out)
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2,
  parameter int CW       = 10
) (
  input logic clk,
  input logic rst_n,
  vga_timing_core_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra bit so a sync pulse ending exactly at H_TOTAL/V_TOTAL still fits.
  localparam logic [CW:0] H_LAST = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] H_VIS  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SS   = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SE   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_LAST = (CW+1)'(V_TOTAL - 1);
  localparam logic [CW:0] V_VIS  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SS   = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SE   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  // Stage layout {hsync, vsync, blank_b, sync_b}; IDLE is the inactive pattern.
  localparam logic [3:0] IDLE = {~HS_POL, ~VS_POL, 1'b0, 1'b1};
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [CW-1:0] h, v, h_n, v_n;
  logic [CW:0] hx, vx;
  logic running, h_end, v_end, vis, hs_on, vs_on;
  logic [3:0] raw, out;
  assign hx = {1'b0, h};
  assign vx = {1'b0, v};
  always_comb begin
    running = state == RUN && rst_n;
    h_end = hx == H_LAST;
    v_end = vx == V_LAST;
    vis = running && hx < H_VIS && vx < V_VIS;
    hs_on = running && hx >= H_SS && hx < H_SE;
    vs_on = running && vx >= V_SS && vx < V_SE;
    raw = {hs_on ? HS_POL : ~HS_POL, vs_on ? VS_POL : ~VS_POL, vis, ~(hs_on | vs_on)};
  end
  // run is only honoured at the last pixel of a frame; the counters wrap to (0,0)
  // on that same edge, so HALT always parks them at the origin.
  always_comb begin
    state_n = state;
    h_n = h;
    v_n = v;
    if (state == HALT)
      state_n = bus.run ? RUN : HALT;
    else if (bus.pix_en) begin
      h_n = h_end ? '0 : h + CW'(1);
      v_n = !h_end ? v : v_end ? '0 : v + CW'(1);
      state_n = (h_end && v_end && !bus.run) ? HALT : RUN;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= bus.run ? RUN : HALT;
      h <= '0;
      v <= '0;
    end else begin
      state <= state_n;
      h <= h_n;
      v <= v_n;
    end
  if (PIPE == 0) begin : g_direct
    assign out = raw;
  end else begin : g_pipe
    logic [3:0] sr [PIPE];
    always_ff @(posedge clk)
      if (!rst_n) begin
        for (int i = 0; i < PIPE; i++) sr[i] <= IDLE;
      end else if (bus.pix_en) begin
        sr[0] <= raw;
        for (int i = 1; i < PIPE; i++) sr[i] <= sr[i-1];
      end
    assign out = sr[PIPE-1];
  end
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt;
  // Counts completed frames only; the wrap that enters HALT (run=0) is not counted.
  always_ff @(posedge clk)
    if (!rst_n) fcnt <= '0;
    else if (running && bus.pix_en && h_end && v_end && bus.run) fcnt <= fcnt + 16'd1;
  assign bus.frame_cnt = fcnt;
`endif
  assign bus.x = h;
  assign bus.y = v;
  assign bus.active = vis;
  assign {bus.hsync, bus.vsync, bus.blank_b, bus.sync_b} = out;
  assign bus.sof = running && bus.pix_en && h == '0 && v == '0;
  assign bus.sol = running && bus.pix_en && h == '0 && vx < V_VIS;
endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed self-checking bench for vga_timing_core (small geometry, PIPE=0 and PIPE=3)
module tb_vga_timing_core;
  logic clk = 1'b0;
  logic rst_n, pix_en, run;
  int checks = 0;
  int errors = 0;
  int pos = 0;
  int n_sof, n_sol, n_act, n_hs, n_vs;
  always #5 clk = ~clk;
  vga_timing_core_if #(.CW(4)) b0 ();
  vga_timing_core_if #(.CW(4)) b3 ();
  assign b0.pix_en = pix_en;
  assign b0.run = run;
  assign b3.pix_en = pix_en;
  assign b3.run = run;
  vga_timing_core #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(0), .CW(4))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  vga_timing_core #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(3), .CW(4))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic to(input int p);
    repeat (p - pos) @(posedge clk);
    #2;
    pos = p;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    run = 1'b1;
    pix_en = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_x", b0.x, 0);
    chk("rst_y", b0.y, 0);
    chk("rst_active", b0.active, 0);
    chk("rst_sof", b0.sof, 0);
    chk("rst_hsync3", b3.hsync, 1);
    chk("rst_vsync3", b3.vsync, 1);
    chk("rst_blank3", b3.blank_b, 0);
    chk("rst_syncb3", b3.sync_b, 1);
    rst_n = 1'b1;
    #1;
    chk("first_sof", b0.sof, 1);
    chk("first_sol", b0.sol, 1);
    chk("first_active", b0.active, 1);
    chk("first_blank0", b0.blank_b, 1);
    chk("first_blank3", b3.blank_b, 0);
    n_sof = 0; n_sol = 0; n_act = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < 120; i++) begin
      n_sof += int'(b0.sof);
      n_sol += int'(b0.sol);
      n_act += int'(b0.active);
      n_hs += int'(!b0.hsync);
      n_vs += int'(!b0.vsync);
      @(posedge clk);
      #2;
    end
    pos = 120;
    chk("frame_sof_cnt", n_sof, 1);
    chk("frame_sol_cnt", n_sol, 4);
    chk("frame_active_cnt", n_act, 32);
    chk("frame_hs_low", n_hs, 24);
    chk("frame_vs_low", n_vs, 30);
    chk("f2_x", b0.x, 0);
    chk("f2_y", b0.y, 0);
    chk("f2_sof", b0.sof, 1);
    to(122); chk("p3_blank_pre", b3.blank_b, 0);
    to(123); chk("p3_blank_rise", b3.blank_b, 1);
    to(130); chk("hs_start_x", b0.x, 10);
    chk("hs_start", b0.hsync, 0);
    chk("hs_start_syncb", b0.sync_b, 0);
    to(132); chk("p3_syncb_pre", b3.sync_b, 1);
    to(133); chk("p3_syncb_fall", b3.sync_b, 0);
    chk("hs_end", b0.hsync, 1);
    to(194); chk("vs_pre", b0.vsync, 1);
    to(195); chk("vs_start", b0.vsync, 0);
    chk("vs_start_y", b0.y, 5);
    to(224); chk("vs_last", b0.vsync, 0);
    to(225); chk("vs_end", b0.vsync, 1);
    to(240); chk("f3_sof", b0.sof, 1);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_2", b0.frame_cnt, 2);
`endif
    n_sof = 0;
    for (int k = 0; k < 240; k++) begin
      pix_en = (k % 2 == 0);
      #1;
      n_sof += int'(b0.sof);
      if (k == 2) chk("pe_hold_x", b0.x, 1);
      if (k == 3) chk("pe_adv_x", b0.x, 2);
      if (k == 239) begin
        chk("pe_wrap_x", b0.x, 0);
        chk("pe_wrap_y", b0.y, 0);
        chk("pe_idle_sof", b0.sof, 0);
      end
      @(posedge clk);
      #2;
    end
    pix_en = 1'b1;
    #1;
    chk("pe_sof_cnt", n_sof, 1);
    chk("pe_sof_240", b0.sof, 1);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_3", b0.frame_cnt, 3);
`endif
    pos = 0;
    to(33);
    chk("halt_req_x", b0.x, 3);
    chk("halt_req_y", b0.y, 2);
    run = 1'b0;
    to(60); chk("halt_midframe_y", b0.y, 4);
    to(119); chk("halt_last_x", b0.x, 14);
    chk("halt_last_y", b0.y, 7);
    to(120);
    chk("halt_x", b0.x, 0);
    chk("halt_y", b0.y, 0);
    chk("halt_sof", b0.sof, 0);
    chk("halt_active", b0.active, 0);
    chk("halt_blank", b0.blank_b, 0);
    chk("halt_hsync", b0.hsync, 1);
    chk("halt_vsync", b0.vsync, 1);
    to(125);
    chk("halt_hold_x", b0.x, 0);
    chk("halt_blank3", b3.blank_b, 0);
    chk("halt_hsync3", b3.hsync, 1);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_halt", b0.frame_cnt, 3);
`endif
    run = 1'b1;
    #1;
    chk("halt_sof_pre", b0.sof, 0);
    to(126);
    chk("resume_sof", b0.sof, 1);
    chk("resume_active", b0.active, 1);
    pos = 0;
    to(50); run = 1'b0;
    to(51); run = 1'b1;
    to(120);
    chk("toggle_no_halt_sof", b0.sof, 1);
    chk("toggle_no_halt_x", b0.x, 0);
    pos = 0;
    to(95);
    chk("pre_rst_x", b0.x, 5);
    chk("pre_rst_y", b0.y, 6);
    rst_n = 1'b0;
    to(96);
    chk("mid_rst_x", b0.x, 0);
    chk("mid_rst_y", b0.y, 0);
    chk("mid_rst_blank3", b3.blank_b, 0);
    chk("mid_rst_hsync3", b3.hsync, 1);
    chk("mid_rst_vsync3", b3.vsync, 1);
`ifdef VGA_FRAME_CNT_EN
    chk("mid_rst_fcnt", b0.frame_cnt, 0);
`endif
    rst_n = 1'b1;
    #1;
    chk("post_rst_sof", b0.sof, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
